// File: rtl/ula_seq.sv
// ula_seq: registered W-bit ALU with an iterative shift-add multiply and a tri-stated bus output.
// Latency: 1 cycle for single-cycle opcodes, W cycles for MUL. done pulses when result/flags update.
// Backpressure: none. start is taken every cycle in IDLE and ignored (not queued) while busy.
//
// Ports:
//   clk, clr_n        clock, synchronous active-low reset
//   start, op, A, B   request handshake; operands captured when start is accepted in IDLE
//   Eu                bus enable; Out shows the result register when high, Z otherwise
//   Out               tri-state result bus
//   busy, done        multiply-in-progress level; one-cycle completion pulse
//   flag_z/c/n/v      zero, carry/borrow/shift-out, negative, signed overflow
//   illegal           last completed opcode was unassigned
module ula_seq #(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           Eu,
    output logic [W-1:0]   Out,
    output logic           busy,
    output logic           done,
    output logic           flag_z,
    output logic           flag_c,
    output logic           flag_n,
    output logic           flag_v,
    output logic           illegal
);

    localparam int CW = $clog2(W);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR = OPW'(7);
    localparam logic [OPW-1:0] OP_ADC = OPW'(8);
    localparam logic [OPW-1:0] OP_MUL = OPW'(9);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      result_q, result_d;
    logic              z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, ill_q, ill_d;
    logic              done_q, done_d;
    // Multiplier: the multiplicand shifts left inside a 2W accumulator width,
    // the multiplier shifts right so bit 0 always selects the next partial product.
    logic [2*W-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]      mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [W:0]        sum, diff;
    logic [W-1:0]      alu_res;
    logic              alu_c, alu_v, alu_ill;
    logic [2*W-1:0]    acc_step;

    // Single-cycle datapath, evaluated on the live inputs.
    always_comb begin
        // ADC folds in the carry from the previous completion.
        sum     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, (op == OP_ADC) ? c_q : 1'b0};
        diff    = {1'b0, A} - {1'b0, B};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                alu_res = diff[W-1:0];
                alu_c   = diff[W];   // borrow out == (A < B) unsigned
                alu_v   = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                alu_res = {A[W-2:0], 1'b0};
                alu_c   = A[W-1];
                alu_v   = A[W-1] ^ A[W-2];
            end
            OP_SHR: begin
                alu_res = {1'b0, A[W-1:1]};
                alu_c   = A[0];
            end
            OP_MUL: alu_res = '0;    // handled by the iterative path
            default: alu_ill = 1'b1; // result stays 0, so flag_z follows naturally
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        v_d      = v_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, A};
                        mplier_d = B;
                        cnt_d    = '0;
                    end else begin
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        c_d      = alu_c;
                        n_d      = alu_res[W-1];
                        v_d      = alu_v;
                        ill_d    = alu_ill;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last of the W iterations: commit the product this edge.
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = S_IDLE;
                    result_d = acc_step[W-1:0];
                    z_d      = (acc_step[W-1:0] == '0);
                    c_d      = |acc_step[2*W-1:W];
                    n_d      = acc_step[W-1];
                    v_d      = 1'b0;
                    ill_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            v_q      <= v_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Out     = Eu ? result_q : {W{1'bz}};
    assign busy    = (state_q == S_MUL);
    assign done    = done_q;
    assign flag_z  = z_q;
    assign flag_c  = c_q;
    assign flag_n  = n_q;
    assign flag_v  = v_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       Eu = 1'b1;
    logic [3:0] op = 4'd0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    wire  [7:0] Out;
    logic       busy, done, fz, fc, fn, fv, ill;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_c     = 1'b0;   // model's view of flag_c, needed by ADC

    typedef struct packed {
        logic [7:0] res;
        logic       z, c, n, v, ill;
    } exp_t;

    ula_seq #(.W(W), .OPW(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op), .A(A), .B(B), .Eu(Eu),
        .Out(Out), .busy(busy), .done(done), .flag_z(fz), .flag_c(fc),
        .flag_n(fn), .flag_v(fv), .illegal(ill)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode table.
    function automatic exp_t model(input int o, input int a, input int b, input int cin);
        exp_t e;
        int   sa, sb, s, ss, r, ce;
        e  = '0;
        r  = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (o)
            0, 8: begin
                ce  = (o == 8) ? cin : 0;
                s   = a + b + ce;
                r   = s % 256;
                e.c = (s > 255);
                ss  = sa + sb + ce;
                e.v = (ss > 127) || (ss < -128);
            end
            1: begin
                r   = (a - b + 256) % 256;
                e.c = (a < b);
                ss  = sa - sb;
                e.v = (ss > 127) || (ss < -128);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin
                r   = (a * 2) % 256;
                e.c = (a >= 128);
                e.v = ((a >= 128) != (r >= 128));
            end
            7: begin
                r   = a / 2;
                e.c = (a % 2 == 1);
            end
            9: begin
                s   = a * b;
                r   = s % 256;
                e.c = (s > 255);
            end
            default: e.ill = 1'b1;
        endcase
        e.res = r[7:0];
        e.z   = (r == 0);
        e.n   = (r >= 128);
        return e;
    endfunction

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".out"}, Out, e.res);
        chk({tag, ".z"}, fz, e.z);
        chk({tag, ".c"}, fc, e.c);
        chk({tag, ".n"}, fn, e.n);
        chk({tag, ".v"}, fv, e.v);
        chk({tag, ".ill"}, ill, e.ill);
    endtask

    // Called at a negedge; returns at the negedge after done was checked low again.
    task automatic run_op(input string tag, input int o, input int a, input int b, input bit inject);
        exp_t e;
        e     = model(o, a, b, int'(m_c));
        op    = o[3:0];
        A     = a[7:0];
        B     = b[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        op    = 4'($urandom);
        if (o == 9) begin
            chk({tag, ".busy0"}, busy, 1'b1);
            chk({tag, ".done0"}, done, 1'b0);
            for (int i = 1; i < W; i++) begin
                if (inject && i == 2) begin
                    start = 1'b1;
                    op    = 4'($urandom_range(0, 8));
                end
                @(negedge clk);
                start = 1'b0;
                chk($sformatf("%s.busy%0d", tag, i), busy, 1'b1);
                chk($sformatf("%s.done%0d", tag, i), done, 1'b0);
            end
            @(negedge clk);
        end
        chk_result(tag, e);
        m_c = e.c;
        @(negedge clk);
        chk({tag, ".done_low"}, done, 1'b0);
        chk({tag, ".hold"}, Out, e.res);
    endtask

    initial begin
        exp_t e1, e2;

        // Reset state
        clr_n = 1'b0;
        Eu    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.out", Out, 8'h00);
        chk("rst.flags", {fz, fc, fn, fv, ill}, 5'b0);
        clr_n = 1'b1;
        @(negedge clk);

        // ADD with carry out, then bus release
        run_op("add", 0, 8'hF0, 8'h20, 1'b0);
        Eu = 1'b0;
        #1;
        n_tests++;
        assert (Out !== 8'h10) else begin
            n_fail++;
            $error("FAIL eu0.out: observed %0h expected not-driven", Out);
        end
        Eu = 1'b1;
        #1;
        chk("eu1.out", Out, 8'h10);

        // SUB borrow and signed overflow
        run_op("sub_borrow", 1, 8'h05, 8'h07, 1'b0);
        run_op("sub_ovf", 1, 8'h80, 8'h01, 1'b0);

        // ADD producing zero+carry feeds ADC
        run_op("add_wrap", 0, 8'hFF, 8'h01, 1'b0);
        run_op("adc", 8, 8'h01, 8'h01, 1'b0);

        // MUL with an ignored start mid-operation
        run_op("mul", 9, 8'h13, 8'h11, 1'b1);

        // Reset in cycle 4 of a multiply aborts it
        op    = 4'd9;
        A     = 8'h03;
        B     = 8'h04;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        m_c   = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.out", Out, 8'h00);
        chk("abort.flags", {fz, fc, fn, fv, ill}, 5'b0);
        repeat (W) begin
            @(negedge clk);
            chk("abort.no_done", done, 1'b0);
        end
        run_op("mul_fresh", 9, 8'h03, 8'h04, 1'b0);

        // Illegal opcode then a legal SHL clears it
        run_op("illegal", 12, 8'h55, 8'hAA, 1'b0);
        run_op("shl", 6, 8'hC1, 8'h00, 1'b0);

        // Back-to-back single-cycle requests
        e1    = model(0, 8'h12, 8'h34, int'(m_c));
        e2    = model(1, 8'h10, 8'h20, int'(e1.c));
        op    = 4'd0;
        A     = 8'h12;
        B     = 8'h34;
        start = 1'b1;
        @(negedge clk);
        chk_result("b2b1", e1);
        op = 4'd1;
        A  = 8'h10;
        B  = 8'h20;
        @(negedge clk);
        start = 1'b0;
        chk_result("b2b2", e2);
        m_c = e2.c;
        @(negedge clk);
        chk("b2b.done_low", done, 1'b0);

        // Randomised operations against the model
        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rnd%0d", k), $urandom_range(0, 15), $urandom_range(0, 255),
                   $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the SAP-1 combinational ULA.
- Uses an encoded opcode instead of one-hot op strobes.
- Captures operands on a start handshake, registers the result and status flags, and adds an iterative multi-cycle multiply.
- Drives the shared W-bit bus through a tri-state output gated by Eu. It sits between the A/B registers and the bus, sequenced by the controller via start/done.

Parameters:
- W, 8, datapath width in bits (W >= 2).
- OPW, 4, opcode width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  synchronous active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  OPW  opcode, sampled with start.
- A  input  W  operand A, sampled with start.
- B  input  W  operand B, sampled with start.
- Eu  input  1  bus output enable; combinational, no effect on state.
- Out  output  W  result register when Eu=1, else all Z.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when the result and flags update.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / borrow / shifted-out bit.
- flag_n  output  1  result MSB.
- flag_v  output  1  signed overflow.
- illegal  output  1  last completed opcode was unassigned.

Behaviour:
- Reset (clr_n=0 at an edge): state=IDLE, result=0, busy=0, done=0, all flags=0, illegal=0, multiply counter=0. Out is still governed only by Eu, so it shows 0 if Eu=1.
- Reset mid-multiply aborts the operation: no done pulse, and the partial product is discarded.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A
  - 6 SHL: A<<1, LSB filled with 0
  - 7 SHR: logical A>>1
  - 8 ADC: A+B+flag_c, using flag_c as it stood before this op
  - 9 MUL: low W bits of A*B, unsigned
  - 10..15: illegal
- States are IDLE and MUL.
- IDLE, start=1 at edge k, op != 9:
  - result and flags are written at edge k; done=1 for the cycle after edge k.
  - Latency is 1 cycle and the block stays in IDLE.
  - Back-to-back starts are accepted every cycle.
- IDLE, start=1 at edge k, op == 9:
  - A, B and the counter are captured, and the state goes to MUL with busy=1.
  - One shift-add iteration runs per edge, over edges k+1..k+W.
  - At edge k+W: result and flags are written, done=1, busy=0, state returns to IDLE.
  - Latency is W cycles.
- In MUL, start is ignored and no request is queued. A/B/op changes have no effect once captured.
- Illegal opcode: result=0, illegal=1, flag_z=1, other flags 0, done pulses normally. Any legal completion clears illegal.
- Flags update only on completion and hold otherwise.
  - flag_z = (result==0); flag_n = result[W-1].
  - ADD/ADC: C = carry out of bit W-1; V = signed overflow (operands same sign, result sign differs).
  - SUB: C = borrow (A < B unsigned); V = signed overflow of A-B.
  - AND/OR/XOR/NOT: C=0, V=0.
  - SHL: C = A[W-1], V = A[W-1]^A[W-2].
  - SHR: C = A[0], V=0.
  - MUL: C = 1 if the high W bits of the full 2W product are nonzero; V=0.
- Arithmetic is modulo 2^W; internal sums use W+1 bits.
- done never asserts in two consecutive cycles for the same request. It may assert in consecutive cycles for consecutive single-cycle requests.
- Out = Eu ? result : Z, combinationally, in every state including during MUL, when the previous result is shown.

Test Plan:
- W=8, reset, then ADD A=0xF0 B=0x20 -> next cycle result=0x10, C=1, Z=0, N=0, V=0, done one cycle; Eu=0 -> Out=Z.
- SUB A=0x05 B=0x07 -> result 0xFE, C=1, N=1; then SUB A=0x80 B=0x01 -> result 0x7F, V=1, C=0.
- ADD 0xFF+0x01 (C=1, Z=1) then ADC A=0x01 B=0x01 -> result 0x03, Z=0, C=0.
- MUL A=0x13 B=0x11 -> busy for 8 cycles, done at cycle 8, result 0x43, C=1; a start pulse in cycle 3 is ignored and produces no extra done.
- Reset asserted in cycle 4 of MUL A=0x03 B=0x04 -> busy=0, result=0, no done; a fresh MUL gives 0x0C with C=0.
- op=12 -> result 0, illegal=1, Z=1, done pulses; then SHL A=0xC1 -> result 0x82, C=1, V=0, illegal=0.
